// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and helpers for the MEM-stage load/store unit:
//   - state_e      : two-state bus sequencer (IDLE, ACCESS)
//   - F3_*         : funct3 encodings for access size/sign
//   - memwb_t      : contents of the MEM/WB pipeline register
//   - mem_req_t    : a bus request captured when it is launched
//   - helpers      : funct3 legality, alignment, byte enables, lane replication
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
  } memwb_t;

  // A bubble is the all-zero MEM/WB word: no register write, no load select.
  localparam memwb_t MEMWB_BUBBLE = '0;

  typedef struct packed {
    logic [31:0] addr;       // full effective address; low bits pick the load lane
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
  } mem_req_t;

  // Unsigned variants only exist for loads.
  function automatic logic funct3_legal(input logic [2:0] funct3, input logic is_store);
    logic legal;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !is_store;
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // size is funct3[1:0]: 00 byte, 01 halfword, otherwise word.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicating the datum across every lane lets the byte enables alone pick
  // the target bytes, so no address-dependent shifter is needed on the bus.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      2'b00:   lanes = {4{data[7:0]}};
      2'b01:   lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_extender.sv
// -----------------------------------------------------------------------------
// load_extender
// Combinational load formatter: picks the addressed byte/halfword out of the
// returned memory word and sign- or zero-extends it to 32 bits.
//   rdata_i   : word returned by data memory
//   addr_lo_i : effective address bits [1:0]
//   funct3_i  : access size/sign (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   value_o   : value to be written back
// -----------------------------------------------------------------------------
module load_extender
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    // Halfword accesses are aligned by the time they get here, so bit 1 alone
    // selects the lane.
    half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    // NOTE: assigning a default before the case guarantees every path drives
    // value_o, so no latch is inferred for unlisted funct3 codes.
    value_o = rdata_i;
    case (funct3_i)
      F3_B:    value_o = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    value_o = {{16{half_lane[15]}}, half_lane};
      F3_BU:   value_o = {24'b0, byte_lane};
      F3_HU:   value_o = {16'b0, half_lane};
      default: value_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// MEM pipeline stage with a stalling load/store unit in front of a
// request/ready data-memory port, and the MEM/WB pipeline register.
//
// Ports
//   clk, rst                 : clock; synchronous active-high reset
//   clear_pipeline           : flush; the MEM/WB slot becomes a bubble
//   mem_read_in/mem_write_in : EX/MEM M-control (load / store)
//   funct3_in                : access size and sign
//   alu_result_in            : effective address (or ALU result for non-memory ops)
//   alu_read_data_2_in       : store data
//   instruction_11_7_in      : rd
//   reg_write_in, mem_to_reg_in : EX/MEM WB-control
//   dmem_req/we/addr/wdata/be : data-memory request (addr word aligned)
//   dmem_ready, dmem_rdata   : memory completion and read word
//   stall                    : freezes upstream pipeline registers (combinational)
//   misaligned               : one-cycle registered fault pulse
//   read_data_out, alu_result_out, instruction_11_7_out,
//   reg_write_out, mem_to_reg_out : MEM/WB register contents
//
// Operation
//   A legal memory op in IDLE raises dmem_req in that same cycle and moves to
//   ACCESS, where the captured request is held until dmem_ready. MEM/WB is
//   written on the completing edge. Every op passes through IDLE, so the
//   minimum memory latency is two cycles. A flush during ACCESS cannot abort
//   the bus transfer; it is remembered in kill_q and turns the completion into
//   a bubble.
// -----------------------------------------------------------------------------
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int data_bits = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_pipeline,
  input  logic                 mem_read_in,
  input  logic                 mem_write_in,
  input  logic [2:0]           funct3_in,
  input  logic [data_bits-1:0] alu_result_in,
  input  logic [data_bits-1:0] alu_read_data_2_in,
  input  logic [4:0]           instruction_11_7_in,
  input  logic                 reg_write_in,
  input  logic                 mem_to_reg_in,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [data_bits-1:0] dmem_addr,
  output logic [data_bits-1:0] dmem_wdata,
  output logic [3:0]           dmem_be,
  input  logic                 dmem_ready,
  input  logic [data_bits-1:0] dmem_rdata,
  output logic                 stall,
  output logic                 misaligned,
  output logic [data_bits-1:0] read_data_out,
  output logic [data_bits-1:0] alu_result_out,
  output logic [4:0]           instruction_11_7_out,
  output logic                 reg_write_out,
  output logic                 mem_to_reg_out
);

  state_e   state_q, state_d;
  logic     kill_q, kill_d;
  logic     misaligned_q, misaligned_d;
  memwb_t   memwb_q, memwb_d;
  mem_req_t req_q, req_d;

  mem_req_t    req_new;
  logic        op;
  logic        fault;
  logic        launch;
  logic [31:0] load_value;

  logic [31:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;

  // ---------------------------------------------------------------------------
  // Decode of the instruction sitting in EX/MEM
  // ---------------------------------------------------------------------------
  assign op     = mem_read_in | mem_write_in;
  assign fault  = op & (!funct3_legal(funct3_in, mem_write_in)
                        | addr_misaligned(funct3_in, alu_result_in[1:0]));
  assign launch = op & !fault & !clear_pipeline;

  assign req_new = '{
    addr:       alu_result_in,
    we:         mem_write_in,
    wdata:      store_lanes(funct3_in[1:0], alu_read_data_2_in),
    be:         byte_enables(funct3_in[1:0], alu_result_in[1:0]),
    funct3:     funct3_in,
    rd:         instruction_11_7_in,
    reg_write:  reg_write_in,
    mem_to_reg: mem_to_reg_in
  };

  // Lane selection uses the captured address/funct3, which are stable for the
  // whole ACCESS period.
  load_extender u_load_extender (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (req_q.addr[1:0]),
    .funct3_i  (req_q.funct3),
    .value_o   (load_value)
  );

  // ---------------------------------------------------------------------------
  // Next-state, bus and MEM/WB logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    misaligned_d = 1'b0;
    memwb_d      = memwb_q;
    req_d        = req_q;
    dmem_req     = 1'b0;
    bus_addr     = '0;
    bus_we       = 1'b0;
    bus_wdata    = '0;
    bus_be       = '0;
    stall        = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_pipeline) begin
          // A flushed instruction is squashed before it can fault or request.
          memwb_d = MEMWB_BUBBLE;
        end else if (fault) begin
          misaligned_d = 1'b1;
          memwb_d      = MEMWB_BUBBLE;
        end else if (op) begin
          // Request goes out this cycle straight from EX/MEM; it is captured
          // so the bus stays stable regardless of upstream activity.
          dmem_req  = 1'b1;
          bus_addr  = req_new.addr;
          bus_we    = req_new.we;
          bus_wdata = req_new.wdata;
          bus_be    = req_new.be;
          stall     = 1'b1;
          req_d     = req_new;
          state_d   = ACCESS;
        end else begin
          memwb_d = '{
            read_data:  '0,
            alu_result: alu_result_in,
            rd:         instruction_11_7_in,
            reg_write:  reg_write_in,
            mem_to_reg: mem_to_reg_in
          };
        end
      end

      ACCESS: begin
        dmem_req  = 1'b1;
        bus_addr  = req_q.addr;
        bus_we    = req_q.we;
        bus_wdata = req_q.wdata;
        bus_be    = req_q.be;
        if (dmem_ready) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          // A flush arriving on the completion cycle itself also kills it.
          if (kill_q || clear_pipeline || req_q.we) begin
            memwb_d = MEMWB_BUBBLE;
          end else begin
            memwb_d = '{
              read_data:  load_value,
              alu_result: req_q.addr,
              rd:         req_q.rd,
              reg_write:  req_q.reg_write,
              mem_to_reg: req_q.mem_to_reg
            };
          end
        end else begin
          stall  = 1'b1;
          kill_d = kill_q | clear_pipeline;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign dmem_addr  = {bus_addr[31:2], 2'b00};
  assign dmem_we    = bus_we;
  assign dmem_wdata = bus_wdata;
  assign dmem_be    = bus_be;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample its _d value
    // from before the edge, independent of statement order.
    if (rst) begin
      state_q      <= IDLE;
      kill_q       <= 1'b0;
      misaligned_q <= 1'b0;
      memwb_q      <= MEMWB_BUBBLE;
      req_q        <= '0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      misaligned_q <= misaligned_d;
      memwb_q      <= memwb_d;
      req_q        <= req_d;
    end
  end

  assign misaligned           = misaligned_q;
  assign read_data_out        = memwb_q.read_data;
  assign alu_result_out       = memwb_q.alu_result;
  assign instruction_11_7_out = memwb_q.rd;
  assign reg_write_out        = memwb_q.reg_write;
  assign mem_to_reg_out       = memwb_q.mem_to_reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Directed vector table plus randomized transactions against a
// transaction-level model of the MEM-stage load/store unit.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_pipeline;
  logic        mem_read_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in, alu_read_data_2_in;
  logic [4:0]  instruction_11_7_in;
  logic        reg_write_in, mem_to_reg_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall, misaligned;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  instruction_11_7_out;
  logic        reg_write_out, mem_to_reg_out;

  always #5 clk = ~clk;

  mem_stage_lsu #(.data_bits(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .clear_pipeline       (clear_pipeline),
    .mem_read_in          (mem_read_in),
    .mem_write_in         (mem_write_in),
    .funct3_in            (funct3_in),
    .alu_result_in        (alu_result_in),
    .alu_read_data_2_in   (alu_read_data_2_in),
    .instruction_11_7_in  (instruction_11_7_in),
    .reg_write_in         (reg_write_in),
    .mem_to_reg_in        (mem_to_reg_in),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_be              (dmem_be),
    .dmem_ready           (dmem_ready),
    .dmem_rdata           (dmem_rdata),
    .stall                (stall),
    .misaligned           (misaligned),
    .read_data_out        (read_data_out),
    .alu_result_out       (alu_result_out),
    .instruction_11_7_out (instruction_11_7_out),
    .reg_write_out        (reg_write_out),
    .mem_to_reg_out       (mem_to_reg_out)
  );

  // One instruction in EX/MEM plus how the memory and flush behave for it.
  // delay: ACCESS cycle (1-based) on which dmem_ready rises.
  // clear_at: -1 never, 0 in the issue cycle, k in ACCESS cycle k.
  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic [31:0] rdata;
    int          delay;
    int          clear_at;
  } txn_t;

  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        mis;
    int          stalls;
    logic [31:0] rdo;
    logic [31:0] alo;
    logic [4:0]  rdo5;
    logic        rwo;
    logic        m2ro;
  } exp_t;

  typedef struct {
    string name;
    txn_t  t;
    exp_t  e;
  } vec_t;

  int   tests  = 0;
  int   failed = 0;
  exp_t prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic txn_t mk_txn(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] sdata,
                                  input logic [4:0] rd, input logic rw, input logic m2r,
                                  input logic [31:0] rdata, input int delay, input int clear_at);
    txn_t t;
    t.rd_en = rd_en; t.wr_en = wr_en; t.f3 = f3; t.addr = addr; t.sdata = sdata;
    t.rd = rd; t.rw = rw; t.m2r = m2r; t.rdata = rdata; t.delay = delay; t.clear_at = clear_at;
    return t;
  endfunction

  function automatic exp_t mk_exp(input logic req, input logic we, input logic [3:0] be,
                                  input logic [31:0] wdata, input logic mis, input int stalls,
                                  input logic [31:0] rdo, input logic [31:0] alo,
                                  input logic [4:0] rdo5, input logic rwo, input logic m2ro);
    exp_t e;
    e.req = req; e.we = we; e.be = be; e.wdata = wdata; e.mis = mis; e.stalls = stalls;
    e.rdo = rdo; e.alo = alo; e.rdo5 = rdo5; e.rwo = rwo; e.m2ro = m2ro;
    return e;
  endfunction

  // Reference model: computes the architectural outcome of one instruction
  // from access size, lane arithmetic and the handshake timing.
  function automatic exp_t model(input txn_t t);
    exp_t        e;
    int          size, lane;
    logic        is_mem, legal, fault, cl0, killed;
    logic [31:0] v;
    is_mem = t.rd_en || t.wr_en;
    lane   = int'(t.addr % 32'd4);
    size   = (t.f3[1:0] == 2'd0) ? 1 : (t.f3[1:0] == 2'd1) ? 2 : 4;
    if (t.wr_en) legal = (t.f3 <= 3'd2);
    else         legal = (t.f3 <= 3'd2) || (t.f3 == 3'd4) || (t.f3 == 3'd5);
    fault  = is_mem && (!legal || (lane % size != 0));
    cl0    = (t.clear_at == 0);
    killed = (t.clear_at >= 1);
    e = mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e.req    = is_mem && !fault && !cl0;
    e.we     = t.wr_en;
    e.mis    = fault && !cl0;
    e.stalls = e.req ? t.delay : 0;
    e.be     = 4'(((1 << size) - 1) << lane);
    if (size == 1)      e.wdata = t.sdata[7:0] * 32'h0101_0101;
    else if (size == 2) e.wdata = t.sdata[15:0] * 32'h0001_0001;
    else                e.wdata = t.sdata;
    if (!cl0 && !fault) begin
      if (!is_mem) begin
        e.alo = t.addr; e.rdo5 = t.rd; e.rwo = t.rw; e.m2ro = t.m2r;
      end else if (!t.wr_en && !killed) begin
        v = t.rdata >> (8 * lane);
        if (size == 1) begin
          v = v & 32'hFF;
          if (!t.f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2) begin
          v = v & 32'hFFFF;
          if (!t.f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        e.rdo = v; e.alo = t.addr; e.rdo5 = t.rd; e.rwo = t.rw; e.m2ro = t.m2r;
      end
    end
    return e;
  endfunction

  task automatic idle_inputs();
    clear_pipeline = 0; mem_read_in = 0; mem_write_in = 0; funct3_in = 0;
    alu_result_in = 0; alu_read_data_2_in = 0; instruction_11_7_in = 0;
    reg_write_in = 0; mem_to_reg_in = 0; dmem_ready = 0; dmem_rdata = 0;
  endtask

  task automatic check_memwb(input string nm, input exp_t e);
    check($sformatf("%s read_data_out", nm), read_data_out, e.rdo);
    check($sformatf("%s alu_result_out", nm), alu_result_out, e.alo);
    check($sformatf("%s rd_out", nm), {27'b0, instruction_11_7_out}, {27'b0, e.rdo5});
    check($sformatf("%s reg_write_out", nm), {31'b0, reg_write_out}, {31'b0, e.rwo});
    check($sformatf("%s mem_to_reg_out", nm), {31'b0, mem_to_reg_out}, {31'b0, e.m2ro});
  endtask

  // Starts 1 time unit after a rising edge; ends the same way.
  task automatic run_txn(input string nm, input txn_t t, input exp_t e);
    int          stalls;
    bit          hold_ok, bus_ok;
    logic [31:0] exp_addr;
    stalls = 0; hold_ok = 1; bus_ok = 1;
    exp_addr = t.addr & 32'hFFFF_FFFC;
    mem_read_in = t.rd_en; mem_write_in = t.wr_en; funct3_in = t.f3;
    alu_result_in = t.addr; alu_read_data_2_in = t.sdata; instruction_11_7_in = t.rd;
    reg_write_in = t.rw; mem_to_reg_in = t.m2r;
    clear_pipeline = (t.clear_at == 0);
    dmem_ready = 1'b1;  // must be ignored outside ACCESS
    dmem_rdata = $urandom;
    @(negedge clk);
    check($sformatf("%s dmem_req", nm), {31'b0, dmem_req}, {31'b0, e.req});
    if (stall) stalls++;
    if (e.req) begin
      check($sformatf("%s dmem_addr", nm), dmem_addr, exp_addr);
      check($sformatf("%s dmem_we", nm), {31'b0, dmem_we}, {31'b0, e.we});
      if (e.we) begin
        check($sformatf("%s dmem_be", nm), {28'b0, dmem_be}, {28'b0, e.be});
        check($sformatf("%s dmem_wdata", nm), dmem_wdata, e.wdata);
      end
    end
    @(posedge clk); #1;
    if (e.req) begin
      for (int k = 1; k <= t.delay; k++) begin
        dmem_ready     = (k == t.delay);
        clear_pipeline = (k == t.clear_at);
        dmem_rdata     = (k == t.delay) ? t.rdata : $urandom;
        @(negedge clk);
        if (stall) stalls++;
        if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_we !== e.we ||
            (e.we && (dmem_be !== e.be || dmem_wdata !== e.wdata))) bus_ok = 0;
        if (read_data_out !== prev.rdo || alu_result_out !== prev.alo ||
            instruction_11_7_out !== prev.rdo5 || reg_write_out !== prev.rwo ||
            mem_to_reg_out !== prev.m2ro) hold_ok = 0;
        @(posedge clk); #1;
      end
      check($sformatf("%s bus stable", nm), {31'b0, bus_ok}, 32'd1);
      check($sformatf("%s MEM/WB hold", nm), {31'b0, hold_ok}, 32'd1);
    end
    check($sformatf("%s stall cycles", nm), stalls, e.stalls);
    check($sformatf("%s misaligned", nm), {31'b0, misaligned}, {31'b0, e.mis});
    check_memwb(nm, e);
    clear_pipeline = 0;
    dmem_ready = 0;
    prev = e;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    exp_t zero;
    zero = mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    vecs.push_back('{"add",       mk_txn(0,0,3'b000,32'h0000_0010,0,5,1,0,0,1,-1),
                                  mk_exp(0,0,0,0,0,0, 0,32'h10,5,1,0)});
    vecs.push_back('{"lb",        mk_txn(1,0,3'b000,32'h0000_1003,0,7,1,1,32'h80FF_FFFF,3,-1),
                                  mk_exp(1,0,0,0,0,3, 32'hFFFF_FF80,32'h1003,7,1,1)});
    vecs.push_back('{"sh",        mk_txn(0,1,3'b001,32'h0000_2002,32'h0000_ABCD,9,1,0,0,1,-1),
                                  mk_exp(1,1,4'b1100,32'hABCD_ABCD,0,1, 0,0,0,0,0)});
    vecs.push_back('{"lw_mis",    mk_txn(1,0,3'b010,32'h0000_3001,0,3,1,1,0,1,-1),
                                  mk_exp(0,0,0,0,1,0, 0,0,0,0,0)});
    vecs.push_back('{"lhu_kill",  mk_txn(1,0,3'b101,32'h0000_4000,0,4,1,1,32'h1234_F00D,4,2),
                                  mk_exp(1,0,0,0,0,4, 0,0,0,0,0)});
    vecs.push_back('{"lhu_next",  mk_txn(1,0,3'b101,32'h0000_4002,0,6,1,1,32'h8765_0000,1,-1),
                                  mk_exp(1,0,0,0,0,1, 32'h0000_8765,32'h4002,6,1,1)});
    vecs.push_back('{"lh_neg",    mk_txn(1,0,3'b001,32'h0000_5002,0,8,1,1,32'h8001_7FFF,2,-1),
                                  mk_exp(1,0,0,0,0,2, 32'hFFFF_8001,32'h5002,8,1,1)});
    vecs.push_back('{"lbu",       mk_txn(1,0,3'b100,32'h0000_6001,0,10,1,1,32'h0000_A500,1,-1),
                                  mk_exp(1,0,0,0,0,1, 32'h0000_00A5,32'h6001,10,1,1)});
    vecs.push_back('{"sb",        mk_txn(0,1,3'b000,32'h0000_7001,32'h1234_56EF,0,0,0,0,2,-1),
                                  mk_exp(1,1,4'b0010,32'hEFEF_EFEF,0,2, 0,0,0,0,0)});
    vecs.push_back('{"sw",        mk_txn(0,1,3'b010,32'h0000_8000,32'hDEAD_BEEF,0,0,0,0,1,-1),
                                  mk_exp(1,1,4'b1111,32'hDEAD_BEEF,0,1, 0,0,0,0,0)});
    vecs.push_back('{"ld_f3_011", mk_txn(1,0,3'b011,32'h0000_9000,0,1,1,1,0,1,-1),
                                  mk_exp(0,0,0,0,1,0, 0,0,0,0,0)});
    vecs.push_back('{"st_f3_100", mk_txn(0,1,3'b100,32'h0000_A000,32'h55,0,0,0,0,1,-1),
                                  mk_exp(0,1,0,0,1,0, 0,0,0,0,0)});
    vecs.push_back('{"sh_mis",    mk_txn(0,1,3'b001,32'h0000_2001,32'h77,0,0,0,0,1,-1),
                                  mk_exp(0,1,0,0,1,0, 0,0,0,0,0)});
    vecs.push_back('{"alu_after", mk_txn(0,0,3'b000,32'hCAFE_0000,0,31,1,0,0,1,-1),
                                  mk_exp(0,0,0,0,0,0, 0,32'hCAFE_0000,31,1,0)});
    vecs.push_back('{"lw_flush0", mk_txn(1,0,3'b010,32'h0000_B000,0,2,1,1,32'h1111_2222,1,0),
                                  mk_exp(0,0,0,0,0,0, 0,0,0,0,0)});
    vecs.push_back('{"lw",        mk_txn(1,0,3'b010,32'h0000_B004,0,12,1,1,32'hCAFE_F00D,2,-1),
                                  mk_exp(1,0,0,0,0,2, 32'hCAFE_F00D,32'hB004,12,1,1)});
    vecs.push_back('{"alu_flush", mk_txn(0,0,3'b000,32'h0000_0055,0,1,1,0,0,1,0),
                                  mk_exp(0,0,0,0,0,0, 0,0,0,0,0)});
    vecs.push_back('{"sw_killrdy",mk_txn(0,1,3'b010,32'h0000_C000,32'h1122_3344,0,0,0,0,2,2),
                                  mk_exp(1,1,4'b1111,32'h1122_3344,0,2, 0,0,0,0,0)});

    // Reset state and the cycle after it.
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset dmem_req", {31'b0, dmem_req}, 32'd0);
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset misaligned", {31'b0, misaligned}, 32'd0);
    check_memwb("reset", zero);
    prev = zero;
    @(posedge clk); #1;

    foreach (vecs[i]) run_txn(vecs[i].name, vecs[i].t, vecs[i].e);

    // Reset in the middle of an ACCESS, together with flush and ready.
    run_txn("pre_rst", mk_txn(0,0,3'b000,32'h0BAD_F00D,0,17,1,1,0,1,-1),
            mk_exp(0,0,0,0,0,0, 0,32'h0BAD_F00D,17,1,1));
    mem_read_in = 1; funct3_in = 3'b010; alu_result_in = 32'h0000_D000;
    instruction_11_7_in = 5'd1; reg_write_in = 1; mem_to_reg_in = 1;
    @(negedge clk);
    check("rst_seq launch dmem_req", {31'b0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1; clear_pipeline = 1; dmem_ready = 1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    idle_inputs();
    rst = 0;
    @(negedge clk);
    check("rst_seq dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst_seq stall", {31'b0, stall}, 32'd0);
    check("rst_seq misaligned", {31'b0, misaligned}, 32'd0);
    check_memwb("rst_seq", zero);
    prev = zero;
    @(posedge clk); #1;
    run_txn("post_rst_lw", mk_txn(1,0,3'b010,32'h0000_E008,0,3,1,1,32'h0102_0304,2,-1),
            mk_exp(1,0,0,0,0,2, 32'h0102_0304,32'hE008,3,1,1));

    // Randomized transactions checked against the model.
    for (int n = 0; n < 300; n++) begin
      txn_t t;
      exp_t e;
      int   kind, r;
      logic [2:0] legal_ld[5];
      legal_ld = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      kind = $urandom_range(0, 9);
      t.rd_en = (kind >= 4 && kind <= 6);
      t.wr_en = (kind >= 7);
      if ($urandom_range(0, 4) == 0) t.f3 = 3'($urandom_range(0, 7));
      else if (t.wr_en)              t.f3 = 3'($urandom_range(0, 2));
      else                           t.f3 = legal_ld[$urandom_range(0, 4)];
      t.addr  = $urandom;
      t.sdata = $urandom;
      t.rdata = $urandom;
      t.rd    = 5'($urandom_range(0, 31));
      t.rw    = 1'($urandom_range(0, 1));
      t.m2r   = 1'($urandom_range(0, 1));
      t.delay = $urandom_range(1, 4);
      t.clear_at = -1;
      e = model(t);
      r = $urandom_range(0, 9);
      if (r == 0 && !e.mis)      t.clear_at = 0;
      else if (r == 1 && e.req)  t.clear_at = $urandom_range(1, t.delay);
      e = model(t);
      run_txn($sformatf("rand%0d", n), t, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameter: data_bits, default 32, width of address/data paths; only 32 is supported.
REQ-002 Ports, clock and reset first:
clk  in  1  single clock; all state updates on posedge
rst  in  1  reset, synchronous, active-high
clear_pipeline  in  1  flush; turns the MEM/WB slot into a bubble
mem_read_in  in  1  EX/MEM M-control: load
mem_write_in  in  1  EX/MEM M-control: store
funct3_in  in  3  access size/sign from instruction
alu_result_in  in  32  EX/MEM ALU result (effective address)
alu_read_data_2_in  in  32  EX/MEM store data
instruction_11_7_in  in  5  EX/MEM rd
reg_write_in, mem_to_reg_in  in  1 each  EX/MEM WB-control
dmem_req  out  1  data memory request
dmem_we  out  1  write strobe
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ready  in  1  memory completes the current request
dmem_rdata  in  32  read word, valid when dmem_ready=1
stall  out  1  freezes the IF/ID/EX/MEM upstream registers
misaligned  out  1  registered one-cycle fault pulse
read_data_out, alu_result_out  out  32 each  MEM/WB data
instruction_11_7_out  out  5  MEM/WB rd
reg_write_out, mem_to_reg_out  out  1 each  MEM/WB WB-control

Function
REQ-003 FSM states: IDLE, ACCESS.
REQ-004 Memory op: op = mem_read_in | mem_write_in.
REQ-005 Fault: fault = op & (illegal funct3 | misaligned address).
REQ-006 Legal funct3: loads 000, 001, 010, 100, 101; stores 000, 001, 010.
REQ-007 Misaligned address: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-008 IDLE, op & !fault & !clear_pipeline: next state ACCESS.
REQ-009 IDLE: dmem_req is asserted in the same cycle.
REQ-010 IDLE, otherwise: stay IDLE.
REQ-011 ACCESS: hold dmem_req=1 with addr, we, wdata and be stable until dmem_ready=1, then return to IDLE.
REQ-012 stall = (IDLE & op & !fault & !clear_pipeline) | (ACCESS & !dmem_ready); stall is combinational.
REQ-013 Non-memory instruction: MEM/WB outputs latch on the next edge; latency 1; no stall.
REQ-014 Memory instruction: MEM/WB outputs latch on the edge where dmem_ready=1 in ACCESS.
REQ-015 While stalled, MEM/WB outputs hold.
REQ-016 Store byte enables: sb gives 4'b0001<<addr[1:0]; sh gives 4'b0011<<addr[1:0]; sw gives 4'b1111.
REQ-017 Store data: wdata replicates the byte or halfword across lanes.
REQ-018 Load extraction: select the lane by addr[1:0]; lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
REQ-019 Stores write a bubble into MEM/WB: reg_write_out=0; read_data_out is don't-care but driven 0.
REQ-020 Fault: no request is issued, misaligned=1 for one cycle, and MEM/WB is written as a bubble (reg_write_out=0, mem_to_reg_out=0).
REQ-021 clear_pipeline in IDLE: MEM/WB gets a bubble on the next edge and no request is issued.
REQ-022 clear_pipeline in ACCESS: the bus request is not aborted; a sticky kill flag is set, the completion writes a bubble, and kill clears on return to IDLE.
REQ-023 dmem_ready outside ACCESS is ignored.
REQ-024 Back-to-back memory ops: each returns to IDLE for at least one cycle, so minimum load/store latency is 2 cycles.

Reset
REQ-025 rst, at the clock edge: state=IDLE, kill=0, misaligned=0, and all MEM/WB outputs=0.
REQ-026 dmem_req=0 and stall=0 in the cycle after reset.
REQ-027 rst overrides clear_pipeline and dmem_ready.
REQ-028 rst during ACCESS abandons the transaction; the memory model tolerates a dropped request.

Structure
REQ-029 Package mem_stage_pkg holds: the FSM state enum; funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
REQ-030 Sub-module load_extender: combinational; (rdata, addr[1:0], funct3) -> 32-bit load value.

Verification
REQ-031 Non-memory op: add result 0x00000010 with rd=5 and reg_write=1 appears on MEM/WB after 1 cycle; stall never rises.
REQ-032 lb from 0x1003, with rdata=0x80FFFFFF and ready on the 3rd ACCESS cycle: read_data_out=0xFFFFFF80; stall high for 3 cycles.
REQ-033 sh to 0x2002, data 0x0000ABCD: dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_we=1; reg_write_out=0 afterwards.
REQ-034 lw from 0x3001: no dmem_req; misaligned pulses 1 cycle; MEM/WB is a bubble.
REQ-035 lhu from 0x4000 with clear_pipeline on the 2nd ACCESS cycle, ready on the 4th: the request completes, MEM/WB is a bubble, and the next op proceeds normally.
REQ-036 rst asserted during ACCESS: on the next cycle state=IDLE, dmem_req=0, and all outputs=0.
